// File: rtl/mux_capture_fifo.sv
// mux_capture_fifo
//   Captures {s, M} from an upstream 2:1 nibble mux into a small FIFO on a
//   debounced press of push_n, and discards the head entry on a debounced
//   press of pop_n. The head entry and the occupancy are shown on the board.
//
// Ports
//   CLOCK_50  in   1   system clock, rising edge
//   Resetn    in   1   asynchronous active-low reset
//   M         in   4   nibble selected by the upstream mux
//   s         in   1   select bit that produced M (stored as a tag)
//   push_n    in   1   capture button, active-low, raw and bouncy
//   pop_n     in   1   discard-head button, active-low, raw and bouncy
//   HEX0      out  7   active-low seven-segment (bit6=g .. bit0=a) of head nibble
//   LEDR      out  10  [3:0] head data, [4] head tag, [7:5] count, [8] full, [9] empty
module mux_capture_fifo #(
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] M,
  input  logic       s,
  input  logic       push_n,
  input  logic       pop_n,
  output logic [6:0] HEX0,
  output logic [9:0] LEDR
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count view for LEDR[7:5]; widened so small DEPTH values still fill 3 bits.
  localparam int LW  = (CW > 3) ? CW : 3;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [6:0]     SEG_DASH = 7'b0111111;

  // Active-low hex digit decode, segment order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = 7'b1000000;
      4'h1:    r = 7'b1111001;
      4'h2:    r = 7'b0100100;
      4'h3:    r = 7'b0110000;
      4'h4:    r = 7'b0011001;
      4'h5:    r = 7'b0010010;
      4'h6:    r = 7'b0000010;
      4'h7:    r = 7'b1111000;
      4'h8:    r = 7'b0000000;
      4'h9:    r = 7'b0010000;
      4'hA:    r = 7'b0001000;
      4'hB:    r = 7'b0000011;
      4'hC:    r = 7'b1000110;
      4'hD:    r = 7'b0100001;
      4'hE:    r = 7'b0000110;
      4'hF:    r = 7'b0001110;
      default: r = SEG_DASH;
    endcase
    return r;
  endfunction

  // Index 0 = push button, index 1 = pop button.
  logic [1:0]     btn_n_s;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     press_q, press_d;
  logic [DBW-1:0] dcnt_q [2];
  logic [DBW-1:0] dcnt_d [2];

  logic [4:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_s, empty_s, do_push_s, do_pop_s;
  logic [4:0]     head_s, led_head_s;
  logic [LW-1:0]  cnt_led_s;

  assign btn_n_s = {pop_n, push_n};

  // Debounce next state: the accepted level only moves after a full run of
  // DEBOUNCE_CYCLES disagreeing cycles; a press pulse marks each 1->0 move.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = {DBW{1'b0}};
      if (sync2_q[i] == deb_q[i]) begin
        dcnt_d[i] = {DBW{1'b0}};
      end else if (dcnt_q[i] == DB_LAST) begin
        deb_d[i]  = sync2_q[i];
        dcnt_d[i] = {DBW{1'b0}};
      end else begin
        dcnt_d[i] = dcnt_q[i] + DBW'(1);
      end
      press_d[i] = deb_q[i] & ~deb_d[i];
    end
  end

  // Synchronizer, debounce and press-pulse registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= {DBW{1'b0}};
    end else begin
      sync1_q <= btn_n_s;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign full_s   = (count_q == FULL_CNT);
  assign empty_s  = (count_q == {CW{1'b0}});
  assign do_pop_s = press_q[1] & ~empty_s;
  // A push while full is still taken when a pop frees the head slot this cycle.
  assign do_push_s = press_q[0] & (~full_s | do_pop_s);

  // FIFO pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are never reset because empty_s masks them.
  always_ff @(posedge CLOCK_50) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= {s, M};
    end
  end

  assign head_s    = mem_q[rd_ptr_q];
  assign cnt_led_s = LW'(count_q);

  // Display decode straight from registered state so updates show one cycle after a pulse.
  always_comb begin
    if (empty_s) begin
      led_head_s = 5'b00000;
      HEX0       = SEG_DASH;
    end else begin
      led_head_s = head_s;
      HEX0       = seg7(head_s[3:0]);
    end
    LEDR = {empty_s, full_s, cnt_led_s[2:0], led_head_s};
  end

endmodule

// File: tb/tb_mux_capture_fifo.sv
module tb_mux_capture_fifo;

  localparam int DEPTH = 4;
  localparam int DB    = 16;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] m;
  logic       s;
  logic       push_n;
  logic       pop_n;
  logic [6:0] hex;
  logic [9:0] ledr;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] seg_tab [16];
  logic [4:0] model_q [$];

  typedef struct {
    bit         pu;
    bit         po;
    logic [3:0] m;
    logic       s;
    logic [9:0] exp_ledr;
    logic [6:0] exp_hex;
  } vec_t;

  vec_t tbl [21];

  mux_capture_fifo #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50(clk),
    .Resetn  (rst_n),
    .M       (m),
    .s       (s),
    .push_n  (push_n),
    .pop_n   (pop_n),
    .HEX0    (hex),
    .LEDR    (ledr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [9:0] mkled(input int cnt, input logic [4:0] head);
    logic [2:0] c3;
    c3 = 3'(cnt);
    return {(cnt == 0), (cnt == DEPTH), c3, (cnt == 0) ? 5'd0 : head};
  endfunction

  function automatic vec_t mkv(input bit pu, input bit po, input logic [3:0] mm, input logic ss,
                               input int cnt, input logic [4:0] head);
    vec_t v;
    v.pu = pu; v.po = po; v.m = mm; v.s = ss;
    v.exp_ledr = mkled(cnt, head);
    v.exp_hex  = (cnt == 0) ? DASH : seg_tab[head[3:0]];
    return v;
  endfunction

  function automatic logic [9:0] model_led();
    int c;
    c = model_q.size();
    return mkled(c, (c == 0) ? 5'd0 : model_q[0]);
  endfunction

  function automatic logic [6:0] model_hex();
    logic [4:0] h;
    if (model_q.size() == 0) return DASH;
    h = model_q[0];
    return seg_tab[h[3:0]];
  endfunction

  // Queue-level behaviour of one press event.
  task automatic model_apply(input bit pu, input bit po, input logic [4:0] e);
    if (po && model_q.size() > 0) void'(model_q.pop_front());
    if (pu && model_q.size() < DEPTH) model_q.push_back(e);
  endtask

  task automatic press(input bit pu, input bit po);
    push_n = ~pu;
    pop_n  = ~po;
    tick(40);
    push_n = 1'b1;
    pop_n  = 1'b1;
    tick(40);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    model_q.delete();
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tbl[0]  = mkv(1, 0, 4'h1, 1'b1, 1, 5'h11);
    tbl[1]  = mkv(1, 0, 4'h2, 1'b0, 2, 5'h11);
    tbl[2]  = mkv(1, 0, 4'h3, 1'b0, 3, 5'h11);
    tbl[3]  = mkv(1, 0, 4'h4, 1'b1, 4, 5'h11);
    tbl[4]  = mkv(1, 0, 4'h5, 1'b0, 4, 5'h11);
    tbl[5]  = mkv(0, 1, 4'h0, 1'b0, 3, 5'h02);
    tbl[6]  = mkv(0, 1, 4'h0, 1'b0, 2, 5'h03);
    tbl[7]  = mkv(0, 1, 4'h0, 1'b0, 1, 5'h14);
    tbl[8]  = mkv(0, 1, 4'h0, 1'b0, 0, 5'h00);
    tbl[9]  = mkv(0, 1, 4'h0, 1'b0, 0, 5'h00);
    tbl[10] = mkv(1, 0, 4'h6, 1'b0, 1, 5'h06);
    tbl[11] = mkv(1, 0, 4'h7, 1'b1, 2, 5'h06);
    tbl[12] = mkv(1, 1, 4'h8, 1'b0, 2, 5'h17);
    tbl[13] = mkv(1, 1, 4'hF, 1'b1, 2, 5'h08);
    tbl[14] = mkv(0, 1, 4'h0, 1'b0, 1, 5'h1F);
    tbl[15] = mkv(1, 1, 4'hC, 1'b0, 1, 5'h0C);
    tbl[16] = mkv(1, 0, 4'hE, 1'b0, 2, 5'h0C);
    tbl[17] = mkv(1, 0, 4'h9, 1'b0, 3, 5'h0C);
    tbl[18] = mkv(1, 0, 4'hB, 1'b1, 4, 5'h0C);
    tbl[19] = mkv(1, 1, 4'hD, 1'b0, 4, 5'h0E);
    tbl[20] = mkv(0, 1, 4'h0, 1'b0, 3, 5'h09);

    rst_n = 1'b0; m = 4'h0; s = 1'b0; push_n = 1'b1; pop_n = 1'b1;
    tick(3);
    chk("in_reset_ledr", 32'(ledr), 32'h200);
    chk("in_reset_hex", 32'(hex), 32'(DASH));
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_ledr", 32'(ledr), 32'h200);

    // Single held press: exact latency, then exactly one capture.
    m = 4'hA; s = 1'b1; push_n = 1'b0;
    tick(18);
    chk("latency_before", 32'(ledr[7:5]), 32'd0);
    tick(1);
    chk("latency_after", 32'(ledr[7:5]), 32'd1);
    tick(21);
    push_n = 1'b1;
    tick(40);
    chk("hold_one_ledr", 32'(ledr), 32'(10'b00_0011_1010));
    chk("hold_one_hex", 32'(hex), 32'(7'b0001000));

    // Short glitch must not capture.
    m = 4'h3; push_n = 1'b0;
    tick(10);
    push_n = 1'b1;
    tick(40);
    chk("glitch_ledr", 32'(ledr), 32'(10'b00_0011_1010));

    // Table-driven sequence: fill, overflow, drain, underflow, push+pop, wrap.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      m = tbl[i].m;
      s = tbl[i].s;
      press(tbl[i].pu, tbl[i].po);
      chk($sformatf("tbl%0d_ledr", i), 32'(ledr), 32'(tbl[i].exp_ledr));
      chk($sformatf("tbl%0d_hex", i), 32'(hex), 32'(tbl[i].exp_hex));
    end

    // Reset in the middle of a debounce with three entries stored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      m = 4'(i + 1); s = 1'b0;
      press(1, 0);
    end
    chk("mid_pre_count", 32'(ledr[7:5]), 32'd3);
    push_n = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #2;
    chk("mid_async_ledr", 32'(ledr), 32'h200);
    chk("mid_async_hex", 32'(hex), 32'(DASH));
    tick(1);
    push_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(60);
    chk("mid_no_spurious", 32'(ledr), 32'h200);

    // A button held through reset release still registers once.
    rst_n = 1'b0; m = 4'h5; s = 1'b0; push_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    push_n = 1'b1;
    tick(40);
    chk("held_thru_reset", 32'(ledr), 32'(mkled(1, 5'h05)));

    // Randomized operations against the queue model.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      m = 4'($urandom);
      s = 1'($urandom);
      if (op == 3) begin
        int len;
        len = int'($urandom_range(1, 12));
        if ($urandom_range(0, 1) == 0) push_n = 1'b0; else pop_n = 1'b0;
        tick(len);
        push_n = 1'b1;
        pop_n  = 1'b1;
        tick(30);
      end else begin
        press(op != 1, op != 0);
        model_apply(op != 1, op != 0, {s, m});
      end
      chk($sformatf("rnd%0d_ledr", i), 32'(ledr), 32'(model_led()));
      chk($sformatf("rnd%0d_hex", i), 32'(hex), 32'(model_hex()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
